// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage RV32IM pipeline. Produces
// the stall / bubble / flush controls for the PC, IF/ID, ID/EX and EX/MEM
// registers. It handles three cases:
//   - load-use hazards between the load in EX and the instruction in ID
//   - redirects (taken branch / jump) resolved in EX
//   - the multi-cycle M-extension unit, which it starts and then waits on
// While the M unit works, the front end is frozen. A watchdog forces release
// if the unit never answers.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   id_rs1_addr_i/rs2     source registers of the instruction in ID
//   id_uses_rs1_i/rs2     the ID instruction actually reads that source
//   ex_mem_read_i         the instruction in EX is a load
//   ex_rd_addr_i          destination register of the instruction in EX
//   ex_muldiv_i           the instruction in EX is a multi-cycle M op
//   ex_redirect_i         branch taken or jump resolved in EX
//   muldiv_done_i         M unit result valid (one-cycle pulse)
//   muldiv_start_o        M unit start pulse
//   pc_stall_o            hold PC
//   if_id_stall_o         hold IF/ID
//   if_id_flush_o         clear IF/ID to NOP
//   id_ex_stall_o         hold ID/EX
//   id_ex_bubble_o        load NOP controls into ID/EX
//   id_ex_flush_o         clear ID/EX on redirect
//   ex_mem_bubble_o       load NOP controls into EX/MEM
//   md_timeout_o          sticky watchdog error
//   stall_cnt_o           saturating count of cycles with pc_stall_o=1
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_mem_read_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_muldiv_i,
  input  logic              ex_redirect_i,
  input  logic              muldiv_done_i,
  output logic              muldiv_start_o,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_stall_o,
  output logic              id_ex_bubble_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_bubble_o,
  output logic              md_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  // Last watchdog value tolerated before the forced release.
  localparam logic [7:0] WD_LAST = 8'(MD_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          wd_cnt_q, wd_cnt_d;
  logic                md_timeout_q, md_timeout_d;
  logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                load_use;
  logic                wd_expired;
  logic                md_release;

  // Ungated control decisions; the reset gate is applied at the ports.
  logic                start_raw;
  logic                pc_stall_raw;
  logic                if_id_stall_raw;
  logic                if_id_flush_raw;
  logic                id_ex_stall_raw;
  logic                id_ex_bubble_raw;
  logic                id_ex_flush_raw;
  logic                ex_mem_bubble_raw;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

  assign wd_expired = (wd_cnt_q == WD_LAST);

  // A done pulse or an expired watchdog both end the wait the same way.
  assign md_release = muldiv_done_i || wd_expired;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      wd_cnt_q     <= 8'd0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    wd_cnt_d     = wd_cnt_q;
    md_timeout_d = md_timeout_q;
    unique case (state_q)
      ST_RUN: begin
        // Redirect outranks a start: the M op in EX is being squashed.
        if (!ex_redirect_i && ex_muldiv_i) begin
          state_d  = ST_MD_WAIT;
          wd_cnt_d = 8'd0;
        end
      end
      ST_MD_WAIT: begin
        wd_cnt_d = wd_cnt_q + 8'd1;
        if (md_release) begin
          state_d = ST_RUN;
          // A done arriving on the last allowed cycle is a normal completion.
          if (!muldiv_done_i) begin
            md_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    start_raw         = 1'b0;
    pc_stall_raw      = 1'b0;
    if_id_stall_raw   = 1'b0;
    if_id_flush_raw   = 1'b0;
    id_ex_stall_raw   = 1'b0;
    id_ex_bubble_raw  = 1'b0;
    id_ex_flush_raw   = 1'b0;
    ex_mem_bubble_raw = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_redirect_i) begin
          // Wrong-path instructions in IF/ID and ID/EX are discarded; any
          // load-use stall they would have caused is moot.
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (ex_muldiv_i) begin
          start_raw         = 1'b1;
          pc_stall_raw      = 1'b1;
          if_id_stall_raw   = 1'b1;
          id_ex_stall_raw   = 1'b1;
          ex_mem_bubble_raw = 1'b1;
        end else if (load_use) begin
          // One bubble suffices: next cycle the load sits in MEM.
          pc_stall_raw     = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_bubble_raw = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // On release everything drops so the result lands in EX/MEM and
        // ID/EX advances in the same cycle.
        if (!md_release) begin
          pc_stall_raw      = 1'b1;
          if_id_stall_raw   = 1'b1;
          id_ex_stall_raw   = 1'b1;
          ex_mem_bubble_raw = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Performance counter: saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // Everything reads as zero while reset is held, including mid-wait.
  assign muldiv_start_o  = rst_n && start_raw;
  assign pc_stall_o      = rst_n && pc_stall_raw;
  assign if_id_stall_o   = rst_n && if_id_stall_raw;
  assign if_id_flush_o   = rst_n && if_id_flush_raw;
  assign id_ex_stall_o   = rst_n && id_ex_stall_raw;
  assign id_ex_bubble_o  = rst_n && id_ex_bubble_raw;
  assign id_ex_flush_o   = rst_n && id_ex_flush_raw;
  assign ex_mem_bubble_o = rst_n && ex_mem_bubble_raw;
  assign md_timeout_o    = rst_n && md_timeout_q;
  assign stall_cnt_o     = rst_n ? stall_cnt_q : '0;

endmodule
